// File: rtl/cpu_int_pkg.sv
// Shared types and defaults for the CPU interrupt priority controller.
package cpu_int_pkg;

    localparam int unsigned NUM_SRC_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

endpackage

// File: rtl/int_src_sync.sv
// One interrupt source: 2-flop synchronizer, history flop, fall detect and pending bit.
module int_src_sync (
    input  logic phi1,
    input  logic rstAll_L,
    input  logic srcL,
    input  logic edgeMode,
    input  logic clrReq,
    output logic pend
);

    logic       s1;
    logic       s2;
    logic       s3;
    logic [2:0] live;
    logic       modeQ;
    logic       fall;

    // live[2] marks s3 as a real post-reset sample, so a source held low through reset never looks like a fall
    assign fall = live[2] & s3 & ~s2;

    always_ff @(posedge phi1 or negedge rstAll_L) begin
        if (!rstAll_L) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            s3    <= 1'b1;
            live  <= 3'b000;
            modeQ <= 1'b0;
            pend  <= 1'b0;
        end else begin
            s1    <= srcL;
            s2    <= s1;
            s3    <= s2;
            live  <= {live[1:0], 1'b1};
            modeQ <= edgeMode;
            if (edgeMode != modeQ) begin
                pend <= 1'b0;
            end else if (edgeMode) begin
                pend <= fall | (pend & ~clrReq);
            end else begin
                pend <= ~s2;
            end
        end
    end

endmodule

// File: rtl/interrupt_priority_ctrl.sv
// Fixed-priority interrupt controller: per-source sync/pending, eligibility, lowest-index-wins grant FSM.
module interrupt_priority_ctrl
    import cpu_int_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_SRC_DEF,
    parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
    input  logic               phi1,
    input  logic               rstAll_L,
    input  logic [NUM_SRC-1:0] src_L,
    input  logic [NUM_SRC-1:0] edge_mode,
    input  logic [NUM_SRC-1:0] mask,
    input  logic               iflag,
    input  logic               fetch_en,
    input  logic               ack,
    input  logic               svc_done,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy
);

    state_t             state;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] clrVec;
    logic               anyElig;
    logic [ID_W-1:0]    winner;

    // Source 0 is non-maskable; all others need mask and a clear I flag
    always_comb begin
        elig = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            elig[i] = pending[i] & ((i == 0) | (mask[i] & ~iflag));
        end
    end

    assign anyElig = |elig;

    always_comb begin
        winner = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (elig[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        clrVec = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            clrVec[i] = (state == REQ) & ack & (int_id == ID_W'(i));
        end
    end

    for (genvar g = 0; g < int'(NUM_SRC); g++) begin : gSrc
        int_src_sync uSrc (
            .phi1     (phi1),
            .rstAll_L (rstAll_L),
            .srcL     (src_L[g]),
            .edgeMode (edge_mode[g]),
            .clrReq   (clrVec[g]),
            .pend     (pending[g])
        );
    end

    // int_id is only loaded on a grant, so it stays frozen through REQ and SERV
    always_ff @(posedge phi1 or negedge rstAll_L) begin
        if (!rstAll_L) begin
            state   <= IDLE;
            int_req <= 1'b0;
            busy    <= 1'b0;
            int_id  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en && anyElig) begin
                        state   <= REQ;
                        int_req <= 1'b1;
                        int_id  <= winner;
                    end
                end
                REQ: begin
                    if (ack) begin
                        state   <= SERV;
                        int_req <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                SERV: begin
                    if (svc_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    int_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
